demux_dispatch_ctrl: RTL and testbench
======================================

# demux_dispatch_ctrl

Sequencing controller for the 1-to-4 demultiplexer path. Accepts data words on a valid/ready input, holds each word in a one-entry output register, and drives the 2-bit channel select plus a one-hot per-channel valid until the addressed consumer accepts it. Destination comes from a round-robin pointer or an explicit per-word destination, chosen by a mode input. Sits between the upstream producer and the four downstream consumers that share the demux.

## Interface
- `W`, 8, data word width.
- `CW`, 8, width of each per-channel dispatch counter (only used when counters are enabled).

- `clk`  input  1  single clock; all state updates on rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `mode`  input  1  0 = round-robin destination, 1 = explicit destination from `in_dest`.
- `in_valid`  input  1  producer has a word.
- `in_data`  input  W  word to dispatch.
- `in_dest`  input  2  destination channel, used only when `mode`=1.
- `in_ready`  output  1  controller can accept a word this cycle.
- `sel`  output  2  channel select for the demux; the destination of the held word.
- `out_data`  output  W  held word, shared by all channels.
- `out_valid`  output  4  one-hot; bit `sel` high while a word is held, all zero otherwise.
- `out_ready`  input  4  per-channel consumer ready.
- `cnt`  output  4*CW  per-channel delivered-word counters, channel i at bits [i*CW +: CW] (counter build only).

## Operation
- Two states: EMPTY (no word held) and FULL (word held, `out_valid[sel]`=1).
- `fire` = FULL and `out_ready[sel]`. `accept` = `in_valid` and `in_ready`.
- `in_ready` = EMPTY or `fire` (combinational; replaces the held word in the same cycle it leaves).
- Transitions: EMPTY + accept → FULL; FULL + fire + accept → FULL with the new word; FULL + fire + no accept → EMPTY; FULL + no fire → FULL with `sel`/`out_data` unchanged.
- On accept: `out_data` ← `in_data`; `sel` ← `in_dest` if `mode`=1, else the round-robin pointer `rr`.
- `rr` advances by 1 mod 4 (3 → 0) only on an accept with `mode`=0. It holds during `mode`=1 and resumes from its held value when mode returns to 0.
- `mode` and `in_dest` are sampled only on accept. Changes while FULL do not affect the held word.
- `out_ready` on a non-selected channel has no effect. `out_valid` never has more than one bit set.
- Reset (asynchronous, any time including mid-transfer): state EMPTY, held word dropped, `sel`=0, `rr`=0, `out_data`=0, `out_valid`=0, `cnt`=0. `in_ready` is 1 after reset.

## Timing
- Latency from accept to `out_valid` is 1 cycle.
- Sustained throughput is 1 word per cycle when the addressed consumer is always ready.
- While FULL and not fired, `sel`, `out_data` and `out_valid` are stable cycle to cycle.
- `in_ready` depends combinationally on `out_ready`. No other input-to-output combinational path exists.

## Configuration
- `DEMUX_DISPATCH_CNT_EN` defined:
  - Four CW-bit counters are built. Counter `sel` increments on each `fire`.
  - Each counter wraps from 2^CW−1 to 0. All counters reset to 0.
- Not defined:
  - No counter logic is built. `cnt` is tied to 0.
  - All other behaviour is identical.

## Test plan
- Reset, then `mode`=0, `out_ready`=4'b1111, words 0x11, 0x22, 0x33, 0x44, 0x55 on consecutive cycles → `sel` sequence 0,1,2,3,0; `out_valid` 0001,0010,0100,1000,0001; one word per cycle; `in_ready` stays 1.
- `mode`=1, `in_dest`=2, word 0xA5, `out_ready`=4'b1011 for 3 cycles then 4'b0100 → `out_valid`=0100 and `out_data`=0xA5 stable for 3 cycles, `in_ready`=0; fire on cycle 4, `in_ready`=1 in that cycle.
- Round-robin resume: `mode`=0 accept 2 words (`sel` 0,1), `mode`=1 `in_dest`=3 accept 1, `mode`=0 accept 1 → `sel` sequence 0,1,3,2.
- Assert `rst` while FULL with `sel`=2 → `out_valid`=0, `sel`=0, `out_data`=0, `cnt`=0 immediately; the next round-robin word goes to channel 0.
- Counter build with CW=2: 5 fires on channel 1 → channel 1 counter reads 1,2,3,0,1; other counters stay 0. Non-counter build: `cnt`=0 throughout.
- Simultaneous fire and accept: FULL on ch0, `out_ready`=0001, `in_valid`=1 with 0x77 → next cycle `out_data`=0x77 and `sel`=1, with no EMPTY cycle between.

Source files
------------

// File: rtl/demux_dispatch_ctrl.sv
// demux_dispatch_ctrl
//   Sequencing controller for a 1-to-4 demux path. It takes words from a
//   valid/ready producer and holds each word in a one-entry output register.
//   It drives the channel select and a one-hot per-channel valid until the
//   addressed consumer accepts the word.
//
//   Destination selection:
//     mode = 0 : round-robin pointer rr, which advances on every accept.
//     mode = 1 : explicit destination taken from in_dest.
//
//   Optional feature (macro DEMUX_DISPATCH_CNT_EN):
//     When defined, four CW-bit per-channel delivered-word counters are
//     built. Each counter wraps around.
//     When undefined, cnt is tied to zero.
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous reset, active high
//   mode       : 0 round-robin, 1 explicit destination
//   in_valid   : producer has a word
//   in_data    : word to dispatch (W bits)
//   in_dest    : explicit destination, used when mode = 1
//   in_ready   : controller can take a word this cycle (combinational)
//   sel        : demux select, destination of the held word
//   out_data   : held word, shared by all channels
//   out_valid  : one-hot valid, bit sel set while a word is held
//   out_ready  : per-channel consumer ready
//   cnt        : per-channel delivered counters, channel i at [i*CW +: CW]

module demux_dispatch_ctrl #(
  parameter int unsigned W  = 8,
  parameter int unsigned CW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mode,
  input  logic            in_valid,
  input  logic [W-1:0]    in_data,
  input  logic [1:0]      in_dest,
  output logic            in_ready,
  output logic [1:0]      sel,
  output logic [W-1:0]    out_data,
  output logic [3:0]      out_valid,
  input  logic [3:0]      out_ready,
  output logic [4*CW-1:0] cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t     state;
  logic [1:0] rr;
  logic       fire;
  logic       accept;
  logic [1:0] dest;

  // Handshake terms. A departing word frees the register in the same cycle.
  assign fire     = (state == FULL) && out_ready[sel];
  assign in_ready = (state == EMPTY) || fire;
  assign accept   = in_valid && in_ready;
  assign dest     = mode ? in_dest : rr;

  // Holding register, select, one-hot valid and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      sel       <= 2'd0;
      rr        <= 2'd0;
      out_data  <= '0;
      out_valid <= 4'b0000;
    end else begin
      if (accept) begin
        state     <= FULL;
        sel       <= dest;
        out_data  <= in_data;
        out_valid <= 4'b0001 << dest;
        // The pointer only moves for round-robin words; explicit words leave it parked.
        if (!mode) begin
          rr <= rr + 2'd1;
        end
      end else if (fire) begin
        state     <= EMPTY;
        out_valid <= 4'b0000;
      end
    end
  end

`ifdef DEMUX_DISPATCH_CNT_EN
  logic [CW-1:0] cnt_q [4];

  // Per-channel delivered-word counters. They wrap naturally at 2^CW.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
    end else if (fire) begin
      cnt_q[sel] <= cnt_q[sel] + CW'(1);
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_cnt
    assign cnt[g*CW +: CW] = cnt_q[g];
  end
`else
  assign cnt = '0;
`endif

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// Directed testbench for demux_dispatch_ctrl. Inputs are driven on the
// falling edge. Outputs are checked 1 time unit later, before the next
// rising edge. Expected counter values follow the DEMUX_DISPATCH_CNT_EN
// build setting.

module tb_demux_dispatch_ctrl;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            mode;
  logic            in_valid;
  logic [W-1:0]    in_data;
  logic [1:0]      in_dest;
  logic            in_ready;
  logic [1:0]      sel;
  logic [W-1:0]    out_data;
  logic [3:0]      out_valid;
  logic [3:0]      out_ready;
  logic [4*CW-1:0] cnt;

  int          n_assert = 0;
  int          n_fail   = 0;
  int unsigned ecnt [4];

  demux_dispatch_ctrl #(.W(W), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_dest   (in_dest),
    .in_ready  (in_ready),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cnt       (cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [4*CW-1:0] exp_cnt();
    logic [4*CW-1:0] r;
    r = '0;
`ifdef DEMUX_DISPATCH_CNT_EN
    for (int i = 0; i < 4; i++) r[i*CW +: CW] = CW'(ecnt[i]);
`endif
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected delivery on channel ch at the next rising edge.
  task automatic inc(input int ch);
    ecnt[ch] = (ecnt[ch] + 1) % (1 << CW);
  endtask

  task automatic clr_cnt();
    for (int i = 0; i < 4; i++) ecnt[i] = 0;
  endtask

  task automatic drv(input logic m, input logic v, input logic [W-1:0] d,
                     input logic [1:0] dst, input logic [3:0] ordy);
    @(negedge clk);
    mode = m; in_valid = v; in_data = d; in_dest = dst; out_ready = ordy;
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [1:0] s, input logic [W-1:0] d,
                         input logic [3:0] ov, input logic irdy);
    chk({tag, ".sel"},      32'(sel),       32'(s));
    chk({tag, ".out_data"}, 32'(out_data),  32'(d));
    chk({tag, ".out_valid"},32'(out_valid), 32'(ov));
    chk({tag, ".in_ready"}, 32'(in_ready),  32'(irdy));
    chk({tag, ".cnt"},      32'(cnt),       32'(exp_cnt()));
  endtask

  // Outputs of a controller with no held word; sel/out_data are not checked.
  task automatic chk_empty(input string tag);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".in_ready"},  32'(in_ready),  32'd1);
    chk({tag, ".cnt"},       32'(cnt),       32'(exp_cnt()));
  endtask

  initial begin
    clr_cnt();
    rst = 1'b1; mode = 1'b0; in_valid = 1'b0; in_data = '0; in_dest = 2'd0; out_ready = 4'b0000;
    #2;
    chk_all("reset", 2'd0, 8'h00, 4'b0000, 1'b1);
    @(negedge clk);
    rst = 1'b0;

    // Round-robin at full throughput.
    drv(1'b0, 1'b1, 8'h11, 2'd0, 4'b1111); chk_all("rr0", 2'd0, 8'h00, 4'b0000, 1'b1);
    drv(1'b0, 1'b1, 8'h22, 2'd0, 4'b1111); chk_all("rr1", 2'd0, 8'h11, 4'b0001, 1'b1); inc(0);
    drv(1'b0, 1'b1, 8'h33, 2'd0, 4'b1111); chk_all("rr2", 2'd1, 8'h22, 4'b0010, 1'b1); inc(1);
    drv(1'b0, 1'b1, 8'h44, 2'd0, 4'b1111); chk_all("rr3", 2'd2, 8'h33, 4'b0100, 1'b1); inc(2);
    drv(1'b0, 1'b1, 8'h55, 2'd0, 4'b1111); chk_all("rr4", 2'd3, 8'h44, 4'b1000, 1'b1); inc(3);
    drv(1'b0, 1'b0, 8'h00, 2'd0, 4'b1111); chk_all("rr5", 2'd0, 8'h55, 4'b0001, 1'b1); inc(0);
    drv(1'b0, 1'b0, 8'h00, 2'd0, 4'b1111); chk_empty("rr_idle");

    // Explicit destination with backpressure. mode/in_dest wiggle while held.
    drv(1'b1, 1'b1, 8'hA5, 2'd2, 4'b1011); chk_empty("bp_acc");
    drv(1'b0, 1'b0, 8'h00, 2'd0, 4'b1011); chk_all("bp1", 2'd2, 8'hA5, 4'b0100, 1'b0);
    drv(1'b1, 1'b0, 8'h00, 2'd3, 4'b1011); chk_all("bp2", 2'd2, 8'hA5, 4'b0100, 1'b0);
    drv(1'b0, 1'b0, 8'h00, 2'd1, 4'b1011); chk_all("bp3", 2'd2, 8'hA5, 4'b0100, 1'b0);
    drv(1'b0, 1'b0, 8'h00, 2'd0, 4'b0100); chk_all("bp4", 2'd2, 8'hA5, 4'b0100, 1'b1); inc(2);
    drv(1'b0, 1'b0, 8'h00, 2'd0, 4'b0000); chk_empty("bp_idle");

    // Asynchronous reset while holding a word on channel 2.
    drv(1'b1, 1'b1, 8'h3C, 2'd2, 4'b0000); chk_empty("ar_acc");
    drv(1'b0, 1'b0, 8'h00, 2'd0, 4'b0000); chk_all("ar_full", 2'd2, 8'h3C, 4'b0100, 1'b0);
    #1 rst = 1'b1;
    #1 clr_cnt();
    chk_all("ar_rst", 2'd0, 8'h00, 4'b0000, 1'b1);
    @(negedge clk);
    rst = 1'b0;

    // Round-robin resumes after an explicit word; the first word goes to channel 0.
    drv(1'b0, 1'b1, 8'h01, 2'd0, 4'b1111); chk_all("rs0", 2'd0, 8'h00, 4'b0000, 1'b1);
    drv(1'b0, 1'b1, 8'h02, 2'd0, 4'b1111); chk_all("rs1", 2'd0, 8'h01, 4'b0001, 1'b1); inc(0);
    drv(1'b1, 1'b1, 8'h03, 2'd3, 4'b1111); chk_all("rs2", 2'd1, 8'h02, 4'b0010, 1'b1); inc(1);
    drv(1'b0, 1'b1, 8'h04, 2'd0, 4'b1111); chk_all("rs3", 2'd3, 8'h03, 4'b1000, 1'b1); inc(3);
    drv(1'b0, 1'b0, 8'h00, 2'd0, 4'b1111); chk_all("rs4", 2'd2, 8'h04, 4'b0100, 1'b1); inc(2);
    drv(1'b0, 1'b0, 8'h00, 2'd0, 4'b1111); chk_empty("rs_idle");

    // Synchronous-looking reset between scenarios.
    @(negedge clk);
    rst = 1'b1;
    #1 clr_cnt();
    chk_all("rst2", 2'd0, 8'h00, 4'b0000, 1'b1);
    @(negedge clk);
    rst = 1'b0;

    // Five deliveries on channel 1. The CW=2 counter wraps 3 -> 0.
    drv(1'b1, 1'b1, 8'hB0, 2'd1, 4'b1111); chk_all("c0", 2'd0, 8'h00, 4'b0000, 1'b1);
    drv(1'b1, 1'b1, 8'hB1, 2'd1, 4'b1111); chk_all("c1", 2'd1, 8'hB0, 4'b0010, 1'b1); inc(1);
    drv(1'b1, 1'b1, 8'hB2, 2'd1, 4'b1111); chk_all("c2", 2'd1, 8'hB1, 4'b0010, 1'b1); inc(1);
    drv(1'b1, 1'b1, 8'hB3, 2'd1, 4'b1111); chk_all("c3", 2'd1, 8'hB2, 4'b0010, 1'b1); inc(1);
    drv(1'b1, 1'b1, 8'hB4, 2'd1, 4'b1111); chk_all("c4", 2'd1, 8'hB3, 4'b0010, 1'b1); inc(1);
    drv(1'b1, 1'b0, 8'h00, 2'd1, 4'b1111); chk_all("c5", 2'd1, 8'hB4, 4'b0010, 1'b1); inc(1);
    drv(1'b1, 1'b0, 8'h00, 2'd1, 4'b1111); chk_empty("c_idle");

    // Fire and accept in the same cycle; then non-selected ready is ignored.
    drv(1'b0, 1'b1, 8'h66, 2'd0, 4'b0001); chk_empty("fa_acc");
    drv(1'b0, 1'b1, 8'h77, 2'd0, 4'b0001); chk_all("fa_both", 2'd0, 8'h66, 4'b0001, 1'b1); inc(0);
    drv(1'b0, 1'b0, 8'h00, 2'd0, 4'b1101); chk_all("fa_new", 2'd1, 8'h77, 4'b0010, 1'b0);
    drv(1'b0, 1'b0, 8'h00, 2'd0, 4'b1101); chk_all("fa_hold", 2'd1, 8'h77, 4'b0010, 1'b0);
    drv(1'b0, 1'b0, 8'h00, 2'd0, 4'b0010); chk_all("fa_fire", 2'd1, 8'h77, 4'b0010, 1'b1); inc(1);
    drv(1'b0, 1'b0, 8'h00, 2'd0, 4'b0000); chk_empty("fa_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
